// File: rtl/filter_buffer_ctrl.sv
// Filter-buffer responder: four single-port banks answer PE-engine reads after one cycle,
// and a round-robin loader fills them whenever the read port leaves a bank free.
module filter_buffer_ctrl #(
    parameter int FILTER_DW = 72,
    parameter int BUF_AW    = 9,
    parameter int NB_FILTER = 4,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_fb_req,
    input  logic [BUF_AW-1:0]    i_fb_addr,
    output logic [FILTER_DW-1:0] o_fb_data0,
    output logic [FILTER_DW-1:0] o_fb_data1,
    output logic [FILTER_DW-1:0] o_fb_data2,
    output logic [FILTER_DW-1:0] o_fb_data3,
    output logic                 o_fb_vld,
    input  logic                 i_load_start,
    input  logic [BUF_AW-1:0]    i_load_base,
    input  logic [CNT_W-1:0]     i_load_words,
    input  logic                 i_wr_vld,
    input  logic [FILTER_DW-1:0] i_wr_data,
    output logic                 o_wr_rdy,
    output logic                 o_load_busy,
    output logic                 o_load_done
);

    localparam int DEPTH = 1 << BUF_AW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [BUF_AW-1:0] base_q,     base_d;
    logic [BUF_AW-1:0] word_off_q, word_off_d;
    logic [CNT_W-1:0]  words_q,    words_d;
    logic [CNT_W-1:0]  acc_q,      acc_d;
    logic [1:0]        bank_sel_q, bank_sel_d;
    logic              fb_vld_q,   fb_vld_d;

    logic              wr_fire;
    logic [BUF_AW-1:0] wr_addr;

    // Reads win: a write is only offered on cycles with no read, so each bank sees one access.
    assign o_wr_rdy = (state_q == ST_LOAD) && !i_fb_req;
    assign wr_fire  = i_wr_vld && o_wr_rdy;
    assign wr_addr  = base_q + word_off_q;

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the case leaves one unassigned (no latch).
        state_d    = state_q;
        base_d     = base_q;
        word_off_d = word_off_q;
        words_d    = words_q;
        acc_d      = acc_q;
        bank_sel_d = bank_sel_q;
        fb_vld_d   = i_fb_req;

        case (state_q)
            ST_IDLE: begin
                if (i_load_start) begin
                    base_d     = i_load_base;
                    words_d    = i_load_words;
                    word_off_d = '0;
                    bank_sel_d = '0;
                    acc_d      = '0;
                    state_d    = (i_load_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (wr_fire) begin
                    bank_sel_d = bank_sel_q + 2'd1;
                    if (bank_sel_q == 2'd3) begin
                        word_off_d = word_off_q + BUF_AW'(1);
                    end
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q + CNT_W'(1) == words_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            word_off_q <= '0;
            words_q    <= '0;
            acc_q      <= '0;
            bank_sel_q <= '0;
            fb_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_off_q <= word_off_d;
            words_q    <= words_d;
            acc_q      <= acc_d;
            bank_sel_q <= bank_sel_d;
            fb_vld_q   <= fb_vld_d;
        end
    end

    for (genvar b = 0; b < NB_FILTER; b++) begin : g_bank
        logic [FILTER_DW-1:0] mem [DEPTH];
        logic [FILTER_DW-1:0] rd_q;
        logic                 wr_en;

        assign wr_en = wr_fire && (bank_sel_q == 2'(b));

        // NOTE: the array has no reset so it maps onto block RAM; stale contents are expected after reset.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= i_wr_data;
            end
        end

        // Output register holds the last read when no request arrives.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_q <= '0;
            end else if (i_fb_req) begin
                rd_q <= mem[i_fb_addr];
            end
        end
    end

    assign o_fb_data0  = g_bank[0].rd_q;
    assign o_fb_data1  = g_bank[1].rd_q;
    assign o_fb_data2  = g_bank[2].rd_q;
    assign o_fb_data3  = g_bank[3].rd_q;
    assign o_fb_vld    = fb_vld_q;
    assign o_load_busy = (state_q != ST_IDLE);
    assign o_load_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// Randomised bench for filter_buffer_ctrl: a word-indexed bank model plus a load-progress
// tracker predicts read data, ready, busy and done every cycle.
module tb_filter_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_fb_req;
    logic [8:0]  i_fb_addr;
    logic [71:0] o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3;
    logic        o_fb_vld;
    logic        i_load_start;
    logic [8:0]  i_load_base;
    logic [10:0] i_load_words;
    logic        i_wr_vld;
    logic [71:0] i_wr_data;
    logic        o_wr_rdy;
    logic        o_load_busy;
    logic        o_load_done;

    filter_buffer_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_fb_req     (i_fb_req),
        .i_fb_addr    (i_fb_addr),
        .o_fb_data0   (o_fb_data0),
        .o_fb_data1   (o_fb_data1),
        .o_fb_data2   (o_fb_data2),
        .o_fb_data3   (o_fb_data3),
        .o_fb_vld     (o_fb_vld),
        .i_load_start (i_load_start),
        .i_load_base  (i_load_base),
        .i_load_words (i_load_words),
        .i_wr_vld     (i_wr_vld),
        .i_wr_data    (i_wr_data),
        .o_wr_rdy     (o_wr_rdy),
        .o_load_busy  (o_load_busy),
        .o_load_done  (o_load_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents, which words are defined, and load progress.
    logic [71:0] model [4][512];
    bit          known [4][512];
    bit          m_loading;
    bit          m_done;
    int          m_base;
    int          m_words;
    int          m_acc;
    logic [71:0] exp_data [4];
    bit          exp_dk   [4];

    function automatic logic [71:0] dout(input int b);
        case (b)
            0:       return o_fb_data0;
            1:       return o_fb_data1;
            2:       return o_fb_data2;
            default: return o_fb_data3;
        endcase
    endfunction

    function automatic logic [71:0] rnd72();
        logic [71:0] d;
        d[31:0]  = $urandom;
        d[63:32] = $urandom;
        d[71:64] = 8'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_loading = 0;
        m_done    = 0;
        for (int b = 0; b < 4; b++) begin
            exp_data[b] = '0;
            exp_dk[b]   = 1;
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check registered outputs.
    task automatic cycle(input bit req, input logic [8:0] addr, input bit vld, input logic [71:0] data,
                         input bit start, input logic [8:0] base, input logic [10:0] words);
        bit exp_rdy, hs, busy_now, done_n;
        int k;
        i_fb_req     = req;
        i_fb_addr    = addr;
        i_wr_vld     = vld;
        i_wr_data    = data;
        i_load_start = start;
        i_load_base  = base;
        i_load_words = words;
        #1;
        exp_rdy = m_loading && !req;
        total++;
        if (o_wr_rdy !== exp_rdy) begin
            bad++;
            $display("FAIL wr_rdy @%0t: got %b want %b", $time, o_wr_rdy, exp_rdy);
        end
        hs = vld && exp_rdy;
        if (req) begin
            for (int b = 0; b < 4; b++) begin
                exp_data[b] = model[b][addr];
                exp_dk[b]   = known[b][addr];
            end
        end
        busy_now = m_loading || m_done;
        done_n   = 0;
        if (hs) begin
            k = m_acc;
            model[k % 4][(m_base + k / 4) % 512] = data;
            known[k % 4][(m_base + k / 4) % 512] = 1;
            m_acc++;
            if (m_acc == m_words) begin
                m_loading = 0;
                done_n    = 1;
            end
        end
        if (start && !busy_now) begin
            m_base  = int'(base);
            m_words = int'(words);
            m_acc   = 0;
            if (words == 0) done_n = 1;
            else            m_loading = 1;
        end
        @(posedge clk);
        #1;
        m_done       = done_n;
        i_load_start = 0;
        i_wr_vld     = 0;
        i_fb_req     = 0;
        total++;
        if (o_fb_vld !== req) begin
            bad++;
            $display("FAIL fb_vld @%0t: got %b want %b", $time, o_fb_vld, req);
        end
        total++;
        if (o_load_busy !== (m_loading || m_done)) begin
            bad++;
            $display("FAIL load_busy @%0t: got %b want %b", $time, o_load_busy, m_loading || m_done);
        end
        total++;
        if (o_load_done !== m_done) begin
            bad++;
            $display("FAIL load_done @%0t: got %b want %b", $time, o_load_done, m_done);
        end
        for (int b = 0; b < 4; b++) begin
            if (exp_dk[b]) begin
                total++;
                if (dout(b) !== exp_data[b]) begin
                    bad++;
                    $display("FAIL fb_data%0d @%0t: got %h want %h", b, $time, dout(b), exp_data[b]);
                end
            end
        end
    endtask

    // Full load: start pulse then data until the model sees done, with a cycle budget.
    task automatic do_load(input logic [8:0] base, input logic [10:0] words, input int req_mode,
                           input bit seq, input int vld_pct, input logic [8:0] rd_base);
        int          n;
        bit          req;
        bit          vld;
        logic [71:0] d;
        logic [8:0]  a;
        cycle(0, '0, 0, '0, 1, base, words);
        n = 0;
        while ((m_loading || m_done) && n < 400) begin
            case (req_mode)
                1:       req = (n % 2 == 0);
                2:       req = ($urandom_range(0, 1) == 1);
                default: req = 0;
            endcase
            vld = ($urandom_range(0, 99) < vld_pct);
            d   = seq ? 72'(m_acc + 1) : rnd72();
            a   = rd_base + 9'($urandom_range(0, 3));
            cycle(req, a, vld, d, 0, '0, '0);
            n++;
        end
        total++;
        if (m_loading || m_done) begin
            bad++;
            $display("FAIL load_timeout: still busy after %0d cycles, want done", n);
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        #12;
        model_reset();
        total++;
        if ({o_fb_vld, o_wr_rdy, o_load_busy, o_load_done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {o_fb_vld, o_wr_rdy, o_load_busy, o_load_done});
        end
        total++;
        if ({o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3} !== '0) begin
            bad++;
            $display("FAIL reset_data: got nonzero read data, want 0");
        end
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_basic();
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = -1;
        cycle(0, '0, 0, '0, 1, 9'd0, 11'd8);
        if (o_load_busy) busy_cnt++;
        for (int i = 0; i < 9; i++) begin
            cycle(0, '0, 1, 72'(i + 1), 0, '0, '0);
            if (o_load_busy) busy_cnt++;
            if (o_load_done) done_at = i;
        end
        total++;
        if (busy_cnt != 9) begin
            bad++;
            $display("FAIL busy_cycles: got %0d want 9", busy_cnt);
        end
        total++;
        if (done_at != 7) begin
            bad++;
            $display("FAIL done_timing: got %0d want 7", done_at);
        end
    endtask

    task automatic test_read_hold();
        cycle(1, 9'd1, 0, '0, 0, '0, '0);
        total++;
        if ({o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3} !== {72'd5, 72'd6, 72'd7, 72'd8}) begin
            bad++;
            $display("FAIL read_addr1: got %0d %0d %0d %0d want 5 6 7 8", o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3);
        end
        cycle(0, 9'd0, 0, '0, 0, '0, '0);
        total++;
        if ({o_fb_vld, o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3} !== {1'b0, 72'd5, 72'd6, 72'd7, 72'd8}) begin
            bad++;
            $display("FAIL read_hold: got vld=%b %0d %0d %0d %0d want 0 5 6 7 8", o_fb_vld, o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3);
        end
    endtask

    task automatic test_load_with_reads();
        do_load(9'd10, 11'd4, 1, 0, 100, 9'd0);
        cycle(1, 9'd10, 0, '0, 0, '0, '0);
        total++;
        if (o_fb_data3 !== model[3][10]) begin
            bad++;
            $display("FAIL load_reads_bank3: got %h want %h", o_fb_data3, model[3][10]);
        end
    endtask

    task automatic test_addr_wrap();
        do_load(9'd511, 11'd8, 0, 1, 100, 9'd0);
        cycle(1, 9'd0, 0, '0, 0, '0, '0);
        total++;
        if ({o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3} !== {72'd5, 72'd6, 72'd7, 72'd8}) begin
            bad++;
            $display("FAIL wrap_addr0: got %0d %0d %0d %0d want 5 6 7 8", o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3);
        end
        cycle(1, 9'd511, 0, '0, 0, '0, '0);
        total++;
        if ({o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3} !== {72'd1, 72'd2, 72'd3, 72'd4}) begin
            bad++;
            $display("FAIL wrap_addr511: got %0d %0d %0d %0d want 1 2 3 4", o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3);
        end
    endtask

    task automatic test_zero_and_partial();
        logic [71:0] old2, old3;
        cycle(0, '0, 0, '0, 1, 9'd100, 11'd0);
        total++;
        if (o_load_done !== 1'b1) begin
            bad++;
            $display("FAIL zero_words_done: got %b want 1", o_load_done);
        end
        cycle(0, '0, 0, '0, 0, '0, '0);
        do_load(9'd2, 11'd4, 0, 0, 100, 9'd2);
        old2 = model[2][2];
        old3 = model[3][2];
        do_load(9'd1, 11'd6, 2, 0, 80, 9'd1);
        cycle(1, 9'd2, 0, '0, 0, '0, '0);
        total++;
        if (o_fb_data2 !== old2 || o_fb_data3 !== old3) begin
            bad++;
            $display("FAIL partial_keep: got %h %h want %h %h", o_fb_data2, o_fb_data3, old2, old3);
        end
    endtask

    task automatic test_read_after_write();
        logic [71:0] d;
        d = rnd72();
        cycle(0, '0, 0, '0, 1, 9'd30, 11'd1);
        cycle(0, '0, 1, d, 0, '0, '0);
        cycle(1, 9'd30, 0, '0, 0, '0, '0);
        total++;
        if (o_fb_data0 !== d) begin
            bad++;
            $display("FAIL read_after_write: got %h want %h", o_fb_data0, d);
        end
    endtask

    task automatic test_reset_mid_load();
        cycle(0, '0, 0, '0, 1, 9'd40, 11'd8);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, rnd72(), 0, '0, '0);
        cycle(1, 9'd40, 0, '0, 0, '0, '0);
        rstn = 0;
        #1;
        total++;
        if ({o_load_busy, o_load_done, o_fb_vld} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset: got busy/done/vld=%b want 000", {o_load_busy, o_load_done, o_fb_vld});
        end
        model_reset();
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        cycle(0, '0, 0, '0, 1, 9'd50, 11'd4);
        cycle(0, '0, 1, rnd72(), 1, 9'd100, 11'd0);
        while (m_loading) cycle(0, '0, 1, rnd72(), 0, '0, '0);
        cycle(0, '0, 0, '0, 0, '0, '0);
        cycle(1, 9'd50, 0, '0, 0, '0, '0);
        cycle(1, 9'd40, 0, '0, 0, '0, '0);
        total++;
        if (o_fb_data2 !== model[2][40]) begin
            bad++;
            $display("FAIL partial_retained: got %h want %h", o_fb_data2, model[2][40]);
        end
    endtask

    task automatic test_random();
        logic [8:0]  b;
        logic [10:0] w;
        for (int i = 0; i < 8; i++) begin
            b = 9'($urandom_range(0, 511));
            w = 11'($urandom_range(1, 14));
            do_load(b, w, 2, 0, 70, b);
            for (int j = 0; j < 4; j++) cycle(1, b + 9'(j), 0, '0, 0, '0, '0);
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 512; a++) known[b][a] = 0;
        i_fb_req = 0; i_fb_addr = '0; i_load_start = 0; i_load_base = '0;
        i_load_words = '0; i_wr_vld = 0; i_wr_data = '0;
        test_reset();
        test_load_basic();
        test_read_hold();
        test_load_with_reads();
        test_addr_wrap();
        test_zero_and_partial();
        test_read_after_write();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filter_buffer_ctrl.md
Name: filter_buffer_ctrl

Overview:
Filter-buffer responder serving the PE engine's filter-read port. It answers each req/addr with four filter words, one per output-channel bank, after a fixed 1-cycle latency. A load port streams filter words into the four single-port banks round-robin, and the FSM arbitrates reads against writes. Sits between the DMA/filter loader and pe_engine.

Parameters:
FILTER_DW, 72, bits per filter word (K*K*8).
BUF_AW, 9, bank address width; bank depth = 2^BUF_AW words.
NB_FILTER, 4, number of banks (= Tout); fixed at 4 by the port list.
CNT_W, 11, width of load word count (BUF_AW+2).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_fb_req  in  1  read request from PE engine
i_fb_addr  in  BUF_AW  read address, same for all banks
o_fb_data0  out  FILTER_DW  bank 0 read data
o_fb_data1  out  FILTER_DW  bank 1 read data
o_fb_data2  out  FILTER_DW  bank 2 read data
o_fb_data3  out  FILTER_DW  bank 3 read data
o_fb_vld  out  1  read data valid (req delayed 1 cycle)
i_load_start  in  1  one-cycle pulse; starts a load
i_load_base  in  BUF_AW  first word address of the load
i_load_words  in  CNT_W  total words to write across all banks
i_wr_vld  in  1  load data valid
i_wr_data  in  FILTER_DW  load data
o_wr_rdy  out  1  load data accepted when vld&rdy
o_load_busy  out  1  high from start until done
o_load_done  out  1  one-cycle pulse when the last word is written

Behaviour:
- Reset: all outputs 0; FSM=IDLE; bank contents undefined (no clear).
- Read path: i_fb_req at cycle t -> o_fb_dataN = bankN[i_fb_addr] and o_fb_vld=1 at t+1. Back-to-back reqs are allowed every cycle.
- When there is no req, o_fb_dataN holds its last value and o_fb_vld=0.
- Reads always have priority: o_wr_rdy = (state==LOAD) && !i_fb_req, combinational.
- FSM IDLE:
  - i_load_start latches base and count and clears bank_sel=0 and word_off=0.
  - With count==0, go to DONE; otherwise go to LOAD.
  - i_load_start in any other state is ignored.
- FSM LOAD: each handshake (i_wr_vld&&o_wr_rdy) writes bank[bank_sel][base+word_off] = i_wr_data.
  - After the write, bank_sel increments 0..3.
  - On wrap from 3 to 0, word_off increments.
  - When the accepted count reaches i_load_words, go to DONE.
- FSM DONE: o_load_done=1 for exactly one cycle, then IDLE. o_load_busy=1 in LOAD and DONE.
- Partial group: when i_load_words is not a multiple of 4, the unwritten banks of the final address keep their old contents.
- Address wrap: base+word_off is computed modulo 2^BUF_AW and wraps silently.
- Simultaneous read and write to the same address is impossible: write is stalled that cycle, so read returns the old contents.
- A read issued the cycle after a write to the same address returns the new data.
- i_wr_vld outside LOAD is ignored and o_wr_rdy=0.
- Reset mid-load: FSM returns to IDLE, busy/done/vld cleared; partially written data is not invalidated.
- Banks are inferred single-port synchronous RAM; one access per bank per cycle.

Test Plan:
- Reset then load base=0, words=8, data 1..8 with vld held high, no reads -> bank0[0]=1, bank1[0]=2, bank2[0]=3, bank3[0]=4, bank0[1]=5 ... bank3[1]=8. o_load_done pulses one cycle after the 8th handshake; busy was high for 9 cycles.
- After that load, req addr=1 at cycle t -> at t+1 o_fb_data0..3 = 5,6,7,8 and o_fb_vld=1. At t+2 (no req) vld=0 and data holds 5,6,7,8.
- Load words=4 with i_fb_req asserted on alternating cycles -> o_wr_rdy=0 on every req cycle, no word lost or duplicated, done after the 4th accepted word. Reads during the load return correct old data.
- Load base=511, words=8 -> group 0 lands at address 511 and group 1 at address 0 (wrap). Read addr=0 returns words 5..8.
- Load words=0 -> done pulses the cycle after start with no writes. Load words=6 over pre-filled address 2 (base=1) -> bank2[2] and bank3[2] keep their old values.
- Assert rstn low mid-load after 3 words -> busy, done and vld go to 0 immediately. A new start with words=4 completes normally; a second start during LOAD is ignored.
